// File: rtl/iis_tx_frame_ctrl.sv
// IIS transmit FIFO read-side controller: prefetches one L/R frame, hands it to the serializer, flags underruns.
// Optional IIS_TXCTRL_UNDERRUN_CNT_EN builds the saturating underrun counter; otherwise underrun_cnt reads 0.
module iis_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  fifo_vaild,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  frame_req,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  frame_valid,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_L, S_WAIT_L, S_RD_R, S_WAIT_R, S_FULL
  } state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_stage_l, r_stage_r;
  logic [DATA_WIDTH-1:0] r_left, r_right;
  logic                  r_fv, r_ur;
  logic                  w_rd_en, w_deliver, w_under, w_cap_l, w_cap_r;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rd_en   = (r_state == S_RD_L || r_state == S_RD_R) && !fifo_empty && enable;
    w_deliver = frame_req && enable && (r_state == S_FULL);
    w_under   = frame_req && enable && (r_state != S_FULL);
    w_cap_l   = (r_state == S_WAIT_L) && fifo_vaild;
    w_cap_r   = (r_state == S_WAIT_R) && fifo_vaild;
    case (r_state)
      S_IDLE:   if (enable) w_next = S_RD_L;
      S_RD_L:   if (!enable) w_next = S_IDLE; else if (w_rd_en) w_next = S_WAIT_L;
      // an issued read always completes before honouring enable=0
      S_WAIT_L: if (fifo_vaild) w_next = enable ? S_RD_R : S_IDLE;
      S_RD_R:   if (!enable) w_next = S_IDLE; else if (w_rd_en) w_next = S_WAIT_R;
      S_WAIT_R: if (fifo_vaild) w_next = enable ? S_FULL : S_IDLE;
      S_FULL:   if (!enable) w_next = S_IDLE; else if (frame_req) w_next = S_RD_L;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stage_l <= '0;
      r_stage_r <= '0;
    end else begin
      if (w_cap_l) r_stage_l <= fifo_dout;
      if (w_cap_r) r_stage_r <= fifo_dout;
    end
  end

  // mute on underrun; a partially staged frame is kept so L/R stay paired
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_left  <= '0;
      r_right <= '0;
      r_fv    <= 1'b0;
      r_ur    <= 1'b0;
    end else begin
      r_fv <= w_deliver;
      r_ur <= w_under;
      if (w_deliver) begin
        r_left  <= r_stage_l;
        r_right <= r_stage_r;
      end else if (w_under) begin
        r_left  <= '0;
        r_right <= '0;
      end
    end
  end

`ifdef IIS_TXCTRL_UNDERRUN_CNT_EN
  logic [15:0] r_ur_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n)                            r_ur_cnt <= '0;
    else if (w_under && r_ur_cnt != 16'hFFFF) r_ur_cnt <= r_ur_cnt + 16'd1;
  end
  assign underrun_cnt = r_ur_cnt;
`else
  assign underrun_cnt = 16'h0;
`endif

  assign fifo_rd_en  = w_rd_en;
  assign left_data   = r_left;
  assign right_data  = r_right;
  assign frame_valid = r_fv;
  assign underrun    = r_ur;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: doc/iis_tx_frame_ctrl.md
# iis_tx_frame_ctrl

Read-side controller for the IIS transmit sample FIFO. It runs in the FIFO read-clock domain, pops 16-bit samples in left/right pairs and prefetches one complete stereo frame into a staging register. It hands each frame to the IIS serializer on the serializer's frame request, and detects, signals and counts underruns so channel alignment is never lost.

## Interface
- DATA_WIDTH, 16, sample width; equals the FIFO data width.
- clk  in  1  FIFO read clock; every register updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  controller enable (from APB config register).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable; combinational.
- fifo_vaild  in  1  FIFO read-data valid; arrives one cycle after an accepted read.
- fifo_dout  in  DATA_WIDTH  FIFO read data, qualified by fifo_vaild.
- frame_req  in  1  one-cycle pulse from the serializer at each stereo frame boundary.
- left_data  out  DATA_WIDTH  left sample presented to the serializer.
- right_data  out  DATA_WIDTH  right sample presented to the serializer.
- frame_valid  out  1  one-cycle pulse: left_data/right_data were loaded from the FIFO.
- underrun  out  1  one-cycle pulse: frame_req arrived with no complete frame staged.
- underrun_cnt  out  16  saturating underrun count.
- busy  out  1  high when the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RD_L, WAIT_L, RD_R, WAIT_R, FULL.
- IDLE → RD_L when enable=1.
- fifo_rd_en = (state==RD_L || state==RD_R) && !fifo_empty && enable.
- RD_x → WAIT_x when fifo_rd_en=1. While fifo_empty=1, the FSM stays in RD_x.
- WAIT_L: on fifo_vaild, capture fifo_dout into stage_l and go to RD_R.
- WAIT_R: on fifo_vaild, capture fifo_dout into stage_r and go to FULL.
- WAIT_x without fifo_vaild: hold the state. A read already issued is never abandoned.
- FULL: the frame is staged; the FSM stays here until the frame is consumed.
- frame_req with state==FULL:
  - left_data←stage_l, right_data←stage_r, frame_valid=1.
  - FSM → RD_L, or → IDLE if enable=0.
- frame_req with state!=FULL:
  - underrun=1; underrun_cnt increments.
  - left_data/right_data ← 0 (mute).
  - Partial staging (stage_l already captured) is kept and the fetch continues. The next delivered frame is still a matched L/R pair.
- underrun_cnt saturates at 16'hFFFF and clears only on reset.
- enable=0:
  - No new read starts; fifo_rd_en=0.
  - A WAIT_x state completes its capture first, then the FSM goes to IDLE and the staged data is discarded.
  - FULL → IDLE directly.
  - frame_req is ignored: no frame_valid, no underrun, outputs hold their values.
- busy = (state != IDLE).

## Timing
- Reset (rst_n=0 at a clk edge):
  - FSM = IDLE.
  - stage_l, stage_r, left_data, right_data = 0.
  - frame_valid = 0, underrun = 0, underrun_cnt = 0.
  - fifo_rd_en = 0, busy = 0.
- Reset mid-fetch drops any in-flight read result. The FIFO is reset alongside this block.
- Best-case prefetch, with the FIFO non-empty and enable set at edge 0:
  - RD_L at edge 1; rd_en is high during the cycle after edge 1.
  - WAIT_L at edge 2, RD_R at edge 3, WAIT_R at edge 4, FULL at edge 5.
- frame_req sampled at edge t → left_data, right_data, frame_valid / underrun are registered at edge t. They are visible for exactly one cycle after t; data outputs hold until the next load.
- frame_req in the same cycle that WAIT_R captures: this counts as an underrun, because the state is not FULL at that edge. The frame enters FULL and is delivered on the next frame_req.
- Consecutive frame_req pulses must be at least 5 cycles apart for underrun-free operation from a non-empty FIFO.

## Configuration
- IIS_TXCTRL_UNDERRUN_CNT_EN defined: the 16-bit saturating underrun_cnt register is built.
- Macro undefined: underrun_cnt is tied to 16'h0. The underrun pulse and mute behaviour are unchanged.

## Test plan
- Reset then enable with the FIFO preloaded with 0x1111, 0x2222; frame_req at cycle 10 → frame_valid pulse, left_data=0x1111, right_data=0x2222, underrun=0.
- Empty FIFO, enable=1, three frame_req pulses → three underrun pulses, underrun_cnt=3, left_data/right_data=0, fifo_rd_en stays 0.
- FIFO holds only 0xAAAA; frame_req arrives, then 0xBBBB is written; second frame_req → first gives underrun, second gives L=0xAAAA, R=0xBBBB (alignment kept).
- Deassert enable while in WAIT_L with fifo_vaild one cycle later → capture completes, FSM reaches IDLE, busy=0, later frame_req gives no frame_valid and no underrun.
- Force 70000 underruns with the macro defined → underrun_cnt=16'hFFFF; rebuild without the macro → underrun_cnt=0 with underrun pulses unchanged.
- Assert rst_n=0 in WAIT_R after L=0x5555 was captured → all outputs reach their reset values at that edge; after release with fresh data 0x0001, 0x0002, the frame delivered is L=0x0001, R=0x0002.
